ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the forwarded operands, funct3 and Rd of an M-extension instruction held in ID/EX.
- Asserts stall_o so that ID/EX (and all upstream stages) hold while the operation runs.
- Delivers a registered 32-bit result plus a one-cycle done_o pulse to the EX/MEM result mux.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = XLEN.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- valid_i  in  1  ID/EX holds a valid M-extension instruction (opcode 0110011, funct7 0000001).
- funct3_i  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a_i  in  XLEN  rs1 value after the forwarding mux.
- op_b_i  in  XLEN  rs2 value after the forwarding mux.
- rd_i  in  5  destination register.
- flush_i  in  1  branch/jump flush of the EX stage.
- stall_o  out  1  hold request to the PC, IF/ID and ID/EX enables.
- busy_o  out  1  FSM is not IDLE.
- done_o  out  1  result_o/rd_o are valid this cycle.
- result_o  out  XLEN  operation result.
- rd_o  out  5  destination register of result_o.

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, counter=0, all internal registers 0; stall_o=0, busy_o=0, done_o=0, result_o=0, rd_o=0. Reset asserted mid-operation abandons the operation with no done_o.
- FSM states: IDLE, CALC, DONE.
- IDLE -> CALC on a rising edge with valid_i=1 and flush_i=0 and no special case. Latches funct3, rd, operand magnitudes and sign flags; counter=0.
- Special cases (IDLE -> DONE directly, 2-cycle latency):
  - divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return op_a_i.
  - signed overflow (op_a_i=0x80000000, op_b_i=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- CALC: one radix-2 iteration per cycle, counter increments. After the iteration with counter=31, go to DONE. The counter wraps to 0.
  - Multiply: shift-add on the 64-bit product of the unsigned magnitudes.
  - Divide: restoring division; 32-bit quotient and remainder.
- Signedness of magnitudes: MULH/DIV/REM treat both operands as signed; MULHSU treats only op_a as signed; MULHU/DIVU/REMU/MUL treat both as unsigned (MUL low word is sign-independent).
- Result selection, registered into result_o on the CALC->DONE edge:
  - negate the 64-bit product if the sign flags differ;
  - MUL takes bits [31:0]; MULH* take bits [63:32];
  - quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- DONE: done_o=1 for exactly one cycle, stall_o=0 so ID/EX advances at the end of this cycle. Next state is always IDLE; valid_i is ignored in DONE.
- stall_o = (state==IDLE && valid_i && !flush_i) || state==CALC. This is combinational and is deasserted in DONE.
- busy_o = (state != IDLE).
- Latency for the normal path: accept edge, then 32 CALC cycles, then DONE. done_o is high in cycle 33 after the accept cycle (cycle 0).
- result_o and rd_o hold their values until the next DONE.
- flush_i=1 in any state: next state IDLE, counter cleared, done_o not asserted, result_o unchanged. flush_i has priority over accept.
- Operands are sampled only at accept; later changes on op_a_i/op_b_i have no effect.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD -> stall_o high for cycles 0..32; done_o in cycle 33; result_o=0xFFFFFFEB; rd_o=rd_i.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; all in cycle 33.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5 with done_o in cycle 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0 with done_o in cycle 1.
- flush_i pulse at CALC counter=10 -> IDLE next cycle, stall_o=0, no done_o, result_o unchanged. A new MUL 3x4 accepted afterwards -> 12.
- rstn low mid-CALC -> outputs 0 immediately. Back-to-back MUL then DIVU -> two done_o pulses, 34 cycles apart (DONE cycle, then IDLE accept).

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add
// multiply and restoring divide, one bit per cycle, with early-out special cases.
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       f3_q;
    logic [4:0]       rd_q;
    logic             neg_a_q, neg_b_q;
    logic [XLEN-1:0]  opnd_q, hi_q, lo_q;

    logic            accept, signed_a, signed_b, neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    logic [XLEN:0]     mul_sum, div_shift;
    logic              div_ok;
    logic [XLEN-1:0]   nxt_hi, nxt_lo;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, calc_res;

    // Operand decode and early-out detection at accept
    always_comb begin
        accept   = (state_q == IDLE) && valid_i && !flush_i;
        signed_a = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                   (funct3_i == 3'b100) || (funct3_i == 3'b110);
        signed_b = (funct3_i == 3'b001) || (funct3_i == 3'b100) ||
                   (funct3_i == 3'b110);
        neg_a    = signed_a && op_a_i[XLEN-1];
        neg_b    = signed_b && op_b_i[XLEN-1];
        mag_a    = neg_a ? -op_a_i : op_a_i;
        mag_b    = neg_b ? -op_b_i : op_b_i;
        div_zero = funct3_i[2] && (op_b_i == '0);
        div_ovf  = funct3_i[2] && !funct3_i[0] &&
                   (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
        special  = div_zero || div_ovf;
        if (div_zero)
            special_res = funct3_i[1] ? op_a_i : '1;
        else
            special_res = funct3_i[1] ? '0 : op_a_i;
    end

    // hi_q:lo_q is the product/multiplier pair for MUL*, remainder/quotient for DIV*
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_ok    = (div_shift >= {1'b0, opnd_q});
        if (f3_q[2]) begin
            nxt_hi = div_ok ? (div_shift[XLEN-1:0] - opnd_q) : div_shift[XLEN-1:0];
            nxt_lo = {lo_q[XLEN-2:0], div_ok};
        end else begin
            nxt_hi = mul_sum[XLEN:1];
            nxt_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod   = {nxt_hi, nxt_lo};
        prod_s = (neg_a_q ^ neg_b_q) ? -prod : prod;
        quo_s  = (neg_a_q ^ neg_b_q) ? -nxt_lo : nxt_lo;
        rem_s  = neg_a_q ? -nxt_hi : nxt_hi;
        if (f3_q[2])
            calc_res = f3_q[1] ? rem_s : quo_s;
        else
            calc_res = (f3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = special ? DONE : CALC;
            CALC: if (cnt_q == '1) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
        stall_o = rstn && (accept || (state_q == CALC));
        busy_o  = (state_q != IDLE);
        done_o  = (state_q == DONE) && !flush_i;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_o <= '0;
            rd_o     <= '0;
        end else if (flush_i) begin
            cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    cnt_q   <= '0;
                    f3_q    <= funct3_i;
                    rd_q    <= rd_i;
                    neg_a_q <= neg_a;
                    neg_b_q <= neg_b;
                    opnd_q  <= mag_b;
                    hi_q    <= '0;
                    lo_q    <= mag_a;
                    if (special) begin
                        result_o <= special_res;
                        rd_o     <= rd_i;
                    end
                end
                CALC: begin
                    hi_q  <= nxt_hi;
                    lo_q  <= nxt_lo;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        result_o <= calc_res;
                        rd_o     <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M cases, random operations
// against an arithmetic reference, flush, reset and back-to-back scenarios.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid_i, flush_i;
    logic [2:0]  funct3_i;
    logic [31:0] op_a_i, op_b_i;
    logic [4:0]  rd_i;
    logic        stall_o, busy_o, done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_exp = '0;

    ex_muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk(clk), .rstn(rstn), .valid_i(valid_i), .funct3_i(funct3_i),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .rd_i(rd_i), .flush_i(flush_i),
        .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
        .result_o(result_o), .rd_o(rd_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && ((b == 0) || ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Reference: plain 64-bit / 32-bit arithmetic following the RV32M definitions
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint x, y;
        logic [63:0] p;
        int sa, sb;
        int unsigned ua, ub;
        sa = a; sb = b; ua = a; ub = b;
        x = (f3 == 3'd1 || f3 == 3'd2) ? longint'($signed(a)) : longint'({32'b0, a});
        y = (f3 == 3'd1) ? longint'($signed(b)) : longint'({32'b0, b});
        p = x * y;
        case (f3)
            3'd0: return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : ua / ub;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: return (b == 0) ? a : ua % ub;
        endcase
    endfunction

    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        valid_i = 1'b1; flush_i = 1'b0; funct3_i = f3; op_a_i = a; op_b_i = b; rd_i = rd;
        #1;
        chk("stall_accept", {31'b0, stall_o}, 32'd1);
        chk("busy_idle", {31'b0, busy_o}, 32'd0);
    endtask

    // Drops valid after the accept edge, scrambles inputs, and waits for done_o
    task automatic run_to_done(input logic [31:0] exp_res, input logic [4:0] exp_rd,
                               input int exp_lat, input string tag, input bit tail);
        int n;
        @(negedge clk);
        valid_i = 1'b0; op_a_i = $urandom; op_b_i = $urandom;
        rd_i = 5'($urandom); funct3_i = 3'($urandom);
        #1;
        n = 1;
        while (done_o !== 1'b1 && n < 40) begin
            chk({tag, "_stall_calc"}, {31'b0, stall_o}, 32'd1);
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        chk({tag, "_stall_done"}, {31'b0, stall_o}, 32'd0);
        chk({tag, "_result"}, result_o, exp_res);
        chk({tag, "_rd"}, {27'b0, rd_o}, {27'b0, exp_rd});
        last_exp = exp_res;
        if (tail) begin
            @(negedge clk); #1;
            chk({tag, "_done_pulse"}, {31'b0, done_o}, 32'd0);
            chk({tag, "_hold"}, result_o, exp_res);
        end
    endtask

    task automatic do_dir(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string tag);
        logic [4:0] rd;
        rd = 5'($urandom);
        start_op(f3, a, b, rd);
        run_to_done(exp, rd, lat, tag, 1'b1);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic [4:0]  rd;
        bit          seen;

        rstn = 1'b0; valid_i = 1'b1; flush_i = 1'b0; funct3_i = '0;
        op_a_i = 32'h1234; op_b_i = 32'h5; rd_i = 5'd3;
        #12;
        chk("rst_result", result_o, 32'd0);
        chk("rst_rd", {27'b0, rd_o}, 32'd0);
        chk("rst_done", {31'b0, done_o}, 32'd0);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        @(negedge clk);
        valid_i = 1'b0; rstn = 1'b1;

        do_dir(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
        do_dir(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, "mulh");
        do_dir(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
        do_dir(3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33, "mulhsu");
        do_dir(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, "div");
        do_dir(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, "rem");
        do_dir(3'd5, 32'd100,        32'd7,         32'd14,        33, "divu");
        do_dir(3'd7, 32'd100,        32'd7,         32'd2,         33, "remu");
        do_dir(3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  "divu_zero");
        do_dir(3'd7, 32'd5,          32'd0,         32'd5,         1,  "remu_zero");
        do_dir(3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  "div_zero");
        do_dir(3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 1,  "rem_zero");
        do_dir(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf");
        do_dir(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  "rem_ovf");

        for (int i = 0; i < 48; i++) begin
            f3 = 3'($urandom);
            a  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom;
            endcase
            rd = 5'($urandom);
            start_op(f3, a, b, rd);
            run_to_done(model(f3, a, b), rd, is_special(f3, a, b) ? 1 : 33, "rand", 1'b1);
        end

        // Flush while the counter is at 10 (cycle 11 after accept)
        start_op(3'd0, 32'd9, 32'd9, 5'd7);
        @(negedge clk); valid_i = 1'b0;
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk); flush_i = 1'b0; #1;
        chk("flush_busy", {31'b0, busy_o}, 32'd0);
        chk("flush_stall", {31'b0, stall_o}, 32'd0);
        chk("flush_done", {31'b0, done_o}, 32'd0);
        chk("flush_result", result_o, last_exp);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (done_o === 1'b1) seen = 1'b1;
        end
        chk("flush_no_done", {31'b0, seen}, 32'd0);
        do_dir(3'd0, 32'd3, 32'd4, 32'd12, 33, "mul_after_flush");

        // Back-to-back: valid held across DONE is ignored, accepted in the following IDLE
        start_op(3'd0, 32'd6, 32'd7, 5'd1);
        run_to_done(32'd42, 5'd1, 33, "b2b_mul", 1'b0);
        valid_i = 1'b1; funct3_i = 3'd5; op_a_i = 32'd1000; op_b_i = 32'd9; rd_i = 5'd2;
        #1;
        chk("b2b_stall_in_done", {31'b0, stall_o}, 32'd0);
        @(negedge clk); #1;
        chk("b2b_stall_accept", {31'b0, stall_o}, 32'd1);
        chk("b2b_done_gap_low", {31'b0, done_o}, 32'd0);
        run_to_done(32'd111, 5'd2, 33, "b2b_divu", 1'b1);

        // Reset during CALC
        start_op(3'd4, 32'd12345, 32'd17, 5'd9);
        @(negedge clk); valid_i = 1'b0;
        repeat (5) @(negedge clk);
        rstn = 1'b0; #1;
        chk("midrst_result", result_o, 32'd0);
        chk("midrst_rd", {27'b0, rd_o}, 32'd0);
        chk("midrst_busy", {31'b0, busy_o}, 32'd0);
        chk("midrst_stall", {31'b0, stall_o}, 32'd0);
        chk("midrst_done", {31'b0, done_o}, 32'd0);
        @(negedge clk); rstn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (done_o === 1'b1 || busy_o === 1'b1) seen = 1'b1;
        end
        chk("midrst_abandoned", {31'b0, seen}, 32'd0);
        do_dir(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 33, "mulh_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
